dt_pass_sequencer: RTL and testbench

- Top-level sequencer for the distance-transform datapath.
- Runs three phases in order:
  1. Load: unpacks the 1-bit-per-pixel stimulus ROM (16 pixels per word) into the 8-bit result RAM as 0/1 values.
  2. Forward pass: starts the forward-pass engine.
  3. Backward pass: starts the backward-pass engine.
- Owns the single result-RAM port and multiplexes it between its own loader and the two pass engines.
- Generates `fwpass_finish` and `done` for the top level.

---
 rtl/dt_pass_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dt_pass_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_pass_sequencer.sv
// Distance-transform pass sequencer: loads the packed bitmap into the result
// RAM, then runs the forward and backward pass engines in turn while owning
// and multiplexing the single result-RAM port.
`timescale 1ns/1ps
module dt_pass_sequencer #(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 128,
    parameter int PIX_PER_WORD = 16,
    parameter int STI_AW       = 10,
    parameter int RES_AW       = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    sti_rd,
    output logic [STI_AW-1:0]       sti_addr,
    input  logic [PIX_PER_WORD-1:0] sti_di,
    output logic                    res_rd,
    output logic                    res_wr,
    output logic [RES_AW-1:0]       res_addr,
    output logic [7:0]              res_do,
    output logic                    fw_start,
    input  logic                    fw_done,
    input  logic                    fw_res_rd,
    input  logic                    fw_res_wr,
    input  logic [RES_AW-1:0]       fw_res_addr,
    input  logic [7:0]              fw_res_do,
    output logic                    bw_start,
    input  logic                    bw_done,
    input  logic                    bw_res_rd,
    input  logic                    bw_res_wr,
    input  logic [RES_AW-1:0]       bw_res_addr,
    input  logic [7:0]              bw_res_do,
    output logic                    fwpass_finish,
    output logic                    done
);

    localparam int WORDS = IMG_W * IMG_H / PIX_PER_WORD;
    localparam int PW    = $clog2(PIX_PER_WORD);

    localparam logic [STI_AW-1:0] LAST_W = STI_AW'(WORDS - 1);
    localparam logic [PW-1:0]     LAST_P = PW'(PIX_PER_WORD - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_FW_GO  = 3'd3;
    localparam logic [2:0] S_FW_RUN = 3'd4;
    localparam logic [2:0] S_BW_GO  = 3'd5;
    localparam logic [2:0] S_BW_RUN = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    logic [2:0]              state_reg, state_next;
    logic [STI_AW-1:0]       w_reg, w_next;
    logic [PW-1:0]           p_reg, p_next;
    logic [PIX_PER_WORD-1:0] pix_buf_reg, pix_buf_next;
    logic                    fwpass_finish_reg, fwpass_finish_next;
    logic                    done_reg, done_next;

    // Pixel buffer re-ordered so index p selects pixel p (MSB = leftmost).
    logic [PIX_PER_WORD-1:0] pix_lr;
    logic                    word_end;
    logic                    last_word;

    genvar gi;
    generate
        for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_pix_order
            assign pix_lr[gi] = pix_buf_reg[PIX_PER_WORD-1-gi];
        end
    endgenerate

    assign word_end  = (p_reg == LAST_P);
    assign last_word = (w_reg == LAST_W);

    // Next-state and datapath-register update logic.
    always_comb begin
        state_next         = state_reg;
        w_next             = w_reg;
        p_next             = p_reg;
        pix_buf_next       = pix_buf_reg;
        fwpass_finish_next = fwpass_finish_reg;
        done_next          = done_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    fwpass_finish_next = 1'b0;
                    done_next          = 1'b0;
                    w_next             = '0;
                    state_next         = S_FETCH;
                end
            end
            S_FETCH: begin
                pix_buf_next = sti_di;
                p_next       = '0;
                state_next   = S_LOAD;
            end
            S_LOAD: begin
                if (word_end) begin
                    if (last_word) begin
                        state_next = S_FW_GO;
                    end else begin
                        // Prefetched word arrives at the end of this cycle.
                        pix_buf_next = sti_di;
                        w_next       = w_reg + STI_AW'(1);
                        p_next       = '0;
                    end
                end else begin
                    p_next = p_reg + PW'(1);
                end
            end
            S_FW_GO:  state_next = S_FW_RUN;
            S_FW_RUN: begin
                if (fw_done) begin
                    fwpass_finish_next = 1'b1;
                    state_next         = S_BW_GO;
                end
            end
            S_BW_GO:  state_next = S_BW_RUN;
            S_BW_RUN: begin
                if (bw_done) begin
                    done_next  = 1'b1;
                    state_next = S_FIN;
                end
            end
            S_FIN:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            w_reg             <= '0;
            p_reg             <= '0;
            pix_buf_reg       <= '0;
            fwpass_finish_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            w_reg             <= w_next;
            p_reg             <= p_next;
            pix_buf_reg       <= pix_buf_next;
            fwpass_finish_reg <= fwpass_finish_next;
            done_reg          <= done_next;
        end
    end

    // Output decode: ROM strobes, start pulses and the result-RAM port mux.
    always_comb begin
        sti_rd   = 1'b0;
        sti_addr = '0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        fw_start = 1'b0;
        bw_start = 1'b0;
        case (state_reg)
            S_FETCH: begin
                sti_rd = 1'b1;
            end
            S_LOAD: begin
                res_wr   = 1'b1;
                res_addr = RES_AW'(w_reg) * RES_AW'(PIX_PER_WORD) + RES_AW'(p_reg);
                res_do   = {7'b0, pix_lr[p_reg]};
                if (word_end && !last_word) begin
                    sti_rd   = 1'b1;
                    sti_addr = w_reg + STI_AW'(1);
                end
            end
            S_FW_GO: fw_start = 1'b1;
            S_FW_RUN: begin
                res_rd   = fw_res_rd;
                res_wr   = fw_res_wr;
                res_addr = fw_res_addr;
                res_do   = fw_res_do;
            end
            S_BW_GO: bw_start = 1'b1;
            S_BW_RUN: begin
                res_rd   = bw_res_rd;
                res_wr   = bw_res_wr;
                res_addr = bw_res_addr;
                res_do   = bw_res_do;
            end
            default: ;
        endcase
    end

    assign fwpass_finish = fwpass_finish_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_dt_pass_sequencer.sv
// Self-checking bench for dt_pass_sequencer: ROM and RAM models, stub pass
// engines, and a reference image computed directly from the packed bitmap.
`timescale 1ns/1ps
module tb_dt_pass_sequencer;

    localparam int NPIX  = 16384;
    localparam int NWORD = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di = '0;
    logic        res_rd, res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic        fw_start, bw_start;
    logic        fw_done, bw_done;
    logic        fw_done_stub = 1'b0, bw_done_stub = 1'b0;
    logic        fw_done_spur = 1'b0, bw_done_spur = 1'b0;
    logic        fw_res_rd = 1'b0, fw_res_wr = 1'b0;
    logic [13:0] fw_res_addr = '0;
    logic [7:0]  fw_res_do = '0;
    logic        bw_res_rd = 1'b0, bw_res_wr = 1'b0;
    logic [13:0] bw_res_addr = '0;
    logic [7:0]  bw_res_do = '0;
    logic        fwpass_finish, done;

    assign fw_done = fw_done_stub | fw_done_spur;
    assign bw_done = bw_done_stub | bw_done_spur;

    dt_pass_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
        .fw_start(fw_start), .fw_done(fw_done),
        .fw_res_rd(fw_res_rd), .fw_res_wr(fw_res_wr),
        .fw_res_addr(fw_res_addr), .fw_res_do(fw_res_do),
        .bw_start(bw_start), .bw_done(bw_done),
        .bw_res_rd(bw_res_rd), .bw_res_wr(bw_res_wr),
        .bw_res_addr(bw_res_addr), .bw_res_do(bw_res_do),
        .fwpass_finish(fwpass_finish), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus ROM (latches on negedge) and result RAM models.
    logic [15:0] rom [0:NWORD-1];
    logic [7:0]  ram [0:NPIX-1];
    always @(negedge clk) if (sti_rd) sti_di <= rom[sti_addr];
    always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

    wire all_zero = !sti_rd && (sti_addr == 0) && !res_rd && !res_wr &&
                    (res_addr == 0) && (res_do == 0) && !fw_start &&
                    !bw_start && !fwpass_finish && !done;

    // Event monitor, sampled just after the negedge.
    int   sti_cnt = 0, seq_err = 0, coinc_err = 0, prev_sti_addr = -1;
    int   wr_rise_cyc = -1, fws_cnt = 0, fws_cyc = -1, bws_cyc = -1;
    int   fwd_cyc = -1, bwd_cyc = -1, fpf_rise_cyc = -1, done_rise_cyc = -1;
    logic prev_wr = 1'b0, prev_fpf = 1'b0, prev_done = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (sti_rd) begin
            sti_cnt++;
            if (sti_addr != 0 && int'(sti_addr) != prev_sti_addr + 1) seq_err++;
            if (sti_addr == 0) begin
                if (res_wr) coinc_err++;
            end else if (!(res_wr && int'(res_addr) == 16 * int'(sti_addr) - 1)) begin
                coinc_err++;
            end
            prev_sti_addr = int'(sti_addr);
        end
        if (res_wr && !prev_wr) wr_rise_cyc = cyc;
        prev_wr = res_wr;
        if (fw_start) begin fws_cnt++; fws_cyc = cyc; end
        if (bw_start) bws_cyc = cyc;
        if (fw_done_stub) fwd_cyc = cyc;
        if (bw_done_stub) bwd_cyc = cyc;
        if (fwpass_finish && !prev_fpf) fpf_rise_cyc = cyc;
        prev_fpf = fwpass_finish;
        if (done && !prev_done) done_rise_cyc = cyc;
        prev_done = done;
    end

    // Stub engines: fw writes addr 5, bw writes addr 7; the non-owner
    // engine simultaneously attempts a write that must be ignored.
    initial begin
        forever begin
            @(negedge clk);
            if (fw_start) begin
                repeat (10) @(negedge clk);
                fw_res_wr = 1'b1; fw_res_addr = 14'd5; fw_res_do = 8'hAA;
                bw_res_wr = 1'b1; bw_res_addr = 14'd9; bw_res_do = 8'h77;
                @(negedge clk);
                fw_res_wr = 1'b0; fw_res_addr = '0; fw_res_do = '0;
                bw_res_wr = 1'b0; bw_res_addr = '0; bw_res_do = '0;
                repeat (38) @(negedge clk);
                fw_done_stub = 1'b1;
                @(negedge clk);
                fw_done_stub = 1'b0;
                for (int k = 0; k < 20 && !bw_start; k++) @(negedge clk);
                repeat (5) @(negedge clk);
                bw_res_wr = 1'b1; bw_res_addr = 14'd7;  bw_res_do = 8'h3C;
                fw_res_wr = 1'b1; fw_res_addr = 14'd11; fw_res_do = 8'h66;
                @(negedge clk);
                fw_res_wr = 1'b0; fw_res_addr = '0; fw_res_do = '0;
                bw_res_wr = 1'b0; bw_res_addr = '0; bw_res_do = '0;
                repeat (40) @(negedge clk);
                bw_done_stub = 1'b1;
                @(negedge clk);
                bw_done_stub = 1'b0;
            end
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference pixel: bit (15 - i%16) of word i/16, then engine overwrites.
    function automatic int ref_pix(input int i);
        int v;
        v = (int'(rom[i / 16]) >> (15 - (i % 16))) & 1;
        if (i == 5) v = 8'hAA;
        if (i == 7) v = 8'h3C;
        return v;
    endfunction

    int   s_cyc;
    logic [7:0] snap [0:15];

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input string name, input bit spurious);
        int sti0, fws0, bad, k;
        sti0 = sti_cnt;
        fws0 = fws_cnt;
        pulse_start();
        while (cyc < s_cyc + 5) @(negedge clk);
        chk({name, "_first_wr_lat"}, wr_rise_cyc - s_cyc, 2);
        if (spurious) begin
            while (cyc < s_cyc + 3000) @(negedge clk);
            fw_done_spur = 1'b1; bw_done_spur = 1'b1;
            @(negedge clk);
            fw_done_spur = 1'b0; bw_done_spur = 1'b0;
            repeat (2) @(negedge clk);
            chk({name, "_spur_fpf"}, int'(fwpass_finish), 0);
            chk({name, "_spur_done"}, int'(done), 0);
            chk({name, "_spur_loading"}, int'(res_wr), 1);
        end
        k = 0;
        while (fws_cnt == fws0 && k < 20000) begin @(negedge clk); k++; end
        chk({name, "_fw_start_seen"}, int'(k < 20000), 1);
        chk({name, "_fw_start_lat"}, fws_cyc - s_cyc, 16386);
        for (int i = 0; i < 16; i++) snap[i] = ram[i];
        if (spurious) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 1000) begin @(negedge clk); k++; end
        chk({name, "_done_seen"}, int'(k < 1000), 1);
        repeat (5) @(negedge clk);
        chk({name, "_done_level"}, int'(done), 1);
        chk({name, "_fpf_level"}, int'(fwpass_finish), 1);
        chk({name, "_fw_start_once"}, fws_cnt - fws0, 1);
        chk({name, "_fpf_after_fwdone"}, fpf_rise_cyc - fwd_cyc, 1);
        chk({name, "_bw_start_after_fwdone"}, bws_cyc - fwd_cyc, 1);
        chk({name, "_done_after_bwdone"}, done_rise_cyc - bwd_cyc, 1);
        chk({name, "_sti_reads"}, sti_cnt - sti0, 1024);
        chk({name, "_sti_last_addr"}, prev_sti_addr, 1023);
        chk({name, "_sti_seq_err"}, seq_err, 0);
        chk({name, "_sti_coinc_err"}, coinc_err, 0);
        chk({name, "_ram5"}, int'(ram[5]), 8'hAA);
        chk({name, "_ram7"}, int'(ram[7]), 8'h3C);
        chk({name, "_ram9_ignored"}, int'(ram[9]), ref_pix(9));
        chk({name, "_ram11_ignored"}, int'(ram[11]), ref_pix(11));
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (int'(ram[i]) !== ref_pix(i)) bad++;
        chk({name, "_ram_image_bad"}, bad, 0);
        $display("run %s: start@%0d fw_start@%0d done@%0d", name, s_cyc, fws_cyc, done_rise_cyc);
    endtask

    initial begin
        int bad, sti0, fws0;
        for (int i = 0; i < NWORD; i++) rom[i] = '0;

        // Reset held 3 cycles, then idle for 100 cycles.
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'(all_zero), 1);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!all_zero) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Directed bitmap: word0 = 8001.
        rom[0] = 16'h8001;
        do_run("r1", 1'b0);
        chk("r1_addr0", int'(snap[0]), 1);
        chk("r1_addr15", int'(snap[15]), 1);
        bad = 0;
        for (int i = 1; i < 15; i++) if (snap[i] != 8'h00) bad++;
        chk("r1_addr1_14_zero", bad, 0);

        // Random bitmap with spurious done pulses and a start during FW_RUN.
        for (int i = 0; i < NWORD; i++) rom[i] = 16'($urandom());
        do_run("r2", 1'b1);
        for (int i = 0; i < 16; i++)
            if (i != 5 && i != 7 && i != 9 && i != 11) begin
                chk("r2_snap_pix", int'(snap[i]), ref_pix(i));
            end

        // Reset mid-load while w = 300.
        for (int i = 0; i < NWORD; i++) rom[i] = 16'($urandom());
        sti0 = sti_cnt;
        fws0 = fws_cnt;
        pulse_start();
        while (cyc < s_cyc + 4805) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midload_rst_zero", int'(all_zero), 1);
        chk("midload_sti_reads", sti_cnt - sti0, 301);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midload_idle_zero", int'(all_zero), 1);
        chk("midload_no_fw_start", fws_cnt - fws0, 0);
        $display("run r3a: reset at w=300, cycle %0d", cyc);

        // Fresh random bitmap after the abort; must reload from word 0.
        for (int i = 0; i < NWORD; i++) rom[i] = 16'($urandom());
        do_run("r3", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute watchdog so the bench always terminates.
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
